// File: rtl/repeat_accumulate_buffer_pkg.sv
// ---------------------------------------------------------------------------
// repeat_accumulate_buffer_pkg
//   Shared helpers for the repeat/accumulate buffer.
//   - clog2_min1 : counter width for a range of n values, never below 1 bit.
//   - pass_op_e  : what an accepted input element does to the buffer state,
//                  decoded from the current pass number.
// ---------------------------------------------------------------------------
package repeat_accumulate_buffer_pkg;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,  // first of several passes: overwrite acc slot
        OP_ACCUM = 2'd1,  // middle pass: add into acc slot
        OP_EMIT  = 2'd2   // last pass: sum goes to the output register
    } pass_op_e;

endpackage

// File: rtl/repeat_accumulate_buffer.sv
// ---------------------------------------------------------------------------
// repeat_accumulate_buffer
//   Consumes REPEAT passes of SIZE signed elements and emits SIZE sums,
//   out[i] = sum over p of in[p*SIZE+i], wrapping modulo 2^ACC_WIDTH.
//
//   Ports
//     clk        clock, all state on rising edge
//     rst        asynchronous active-low reset
//     in_data    signed input element (DATA_WIDTH)
//     in_valid   input element present
//     in_ready   element accepted this cycle
//     out_data   signed accumulated element (ACC_WIDTH)
//     out_valid  output element present
//     out_ready  downstream accepts output
//
//   Handshake: a transfer happens on a rising edge where valid && ready.
//   valid never waits on ready; out_valid/out_data hold until accepted.
//   in_ready is a function of state and out_ready only (never in_valid).
// ---------------------------------------------------------------------------
module repeat_accumulate_buffer
    import repeat_accumulate_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REPEAT     = 2,
    parameter int SIZE       = 4,
    parameter int ACC_WIDTH  = DATA_WIDTH + $clog2(REPEAT) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int PTR_W = clog2_min1(SIZE);
    localparam int REP_W = clog2_min1(REPEAT);

    logic [PTR_W-1:0]     ptr;
    logic [REP_W-1:0]     rep;
    logic [ACC_WIDTH-1:0] acc [SIZE];

    logic                 last_ptr;
    logic                 last_rep;
    logic                 xfer;
    logic [ACC_WIDTH-1:0] sext;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [ACC_WIDTH-1:0] emit_val;
    pass_op_e             op;

    assign last_ptr = (ptr == PTR_W'(SIZE - 1));
    assign last_rep = (rep == REP_W'(REPEAT - 1));

    // Only the final pass needs room in the output register; earlier passes
    // keep flowing while the previous block's last output drains.
    assign in_ready = last_rep ? (!out_valid || out_ready) : 1'b1;
    assign xfer     = in_valid && in_ready;

    assign sext     = ACC_WIDTH'($signed(in_data));
    assign acc_sum  = acc[ptr] + sext;
    // With a single pass there is no stored partial sum to add.
    assign emit_val = (REPEAT == 1) ? sext : acc_sum;

    always_comb begin
        op = OP_LOAD;
        if (last_rep)
            op = OP_EMIT;
        else if (rep != '0)
            op = OP_ACCUM;
    end

    // Position counters and output valid: the only state that needs reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            rep       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (xfer) begin
                if (last_ptr) begin
                    ptr <= '0;
                    rep <= last_rep ? '0 : rep + 1'b1;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end

            if (xfer && op == OP_EMIT)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
        end
    end

    // Data path: pass 0 overwrites acc, so neither acc nor out_data is reset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            case (op)
                OP_LOAD:  acc[ptr] <= sext;
                OP_ACCUM: acc[ptr] <= acc_sum;
                OP_EMIT:  out_data <= emit_val;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_repeat_accumulate_buffer.sv
module tb_repeat_accumulate_buffer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // a: DW8 ACC16 R2 S4
    logic [7:0]  in_data_a;  logic in_valid_a, in_ready_a;
    logic [15:0] out_data_a; logic out_valid_a, out_ready_a;
    // b: DW8 ACC16 R3 S2
    logic [7:0]  in_data_b;  logic in_valid_b, in_ready_b;
    logic [15:0] out_data_b; logic out_valid_b, out_ready_b;
    // c: DW8 ACC8 R2 S1
    logic [7:0]  in_data_c;  logic in_valid_c, in_ready_c;
    logic [7:0]  out_data_c; logic out_valid_c, out_ready_c;
    // d: DW8 ACC16 R1 S3
    logic [7:0]  in_data_d;  logic in_valid_d, in_ready_d;
    logic [15:0] out_data_d; logic out_valid_d, out_ready_d;

    logic [15:0] exp_q[$];
    logic [7:0]  a_vec[8];
    logic [15:0] a_exp[4];

    repeat_accumulate_buffer #(.DATA_WIDTH(8), .ACC_WIDTH(16), .REPEAT(2), .SIZE(4)) u_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a));
    repeat_accumulate_buffer #(.DATA_WIDTH(8), .ACC_WIDTH(16), .REPEAT(3), .SIZE(2)) u_b (
        .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b));
    repeat_accumulate_buffer #(.DATA_WIDTH(8), .ACC_WIDTH(8), .REPEAT(2), .SIZE(1)) u_c (
        .clk(clk), .rst(rst), .in_data(in_data_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .out_data(out_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c));
    repeat_accumulate_buffer #(.DATA_WIDTH(8), .ACC_WIDTH(16), .REPEAT(1), .SIZE(3)) u_d (
        .clk(clk), .rst(rst), .in_data(in_data_d), .in_valid(in_valid_d), .in_ready(in_ready_d),
        .out_data(out_data_d), .out_valid(out_valid_d), .out_ready(out_ready_d));

    // ---------------------------------------------------------------- tests
    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid_a: got %b expected 0", out_valid_a); end
        checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b: got %b expected 0", out_valid_b); end
        checks++; if (out_valid_c !== 1'b0) begin errors++; $display("FAIL reset_valid_c: got %b expected 0", out_valid_c); end
        checks++; if (out_valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid_d: got %b expected 0", out_valid_d); end
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready_a: got %b expected 1", in_ready_a); end
        checks++; if (in_ready_b !== 1'b1) begin errors++; $display("FAIL reset_ready_b: got %b expected 1", in_ready_b); end
        checks++; if (in_ready_c !== 1'b1) begin errors++; $display("FAIL reset_ready_c: got %b expected 1", in_ready_c); end
        checks++; if (in_ready_d !== 1'b1) begin errors++; $display("FAIL reset_ready_d: got %b expected 1", in_ready_d); end
    endtask

    // Streams a_vec into u_a with out_ready high; each sum must appear the
    // cycle after its final-pass input.
    task automatic run_a_block(input string tag);
        out_ready_a = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            #1;
            if (i >= 5) begin
                checks++;
                if (out_valid_a !== 1'b1 || out_data_a !== a_exp[i-5]) begin
                    errors++;
                    $display("FAIL %s_out%0d: got valid=%b data=%h expected valid=1 data=%h",
                             tag, i-5, out_valid_a, out_data_a, a_exp[i-5]);
                end
            end else if (i >= 1) begin
                checks++;
                if (out_valid_a !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_idle%0d: got valid=%b expected 0", tag, i, out_valid_a);
                end
            end
            if (i < 8) begin
                checks++;
                if (in_ready_a !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_ready%0d: got %b expected 1", tag, i, in_ready_a);
                end
                in_valid_a = 1'b1;
                in_data_a  = a_vec[i];
            end else begin
                in_valid_a = 1'b0;
            end
        end
    endtask

    task automatic test_basic;
        a_vec = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd20, 8'd30, 8'd40};
        a_exp = '{16'd11, 16'd22, 16'd33, 16'd44};
        run_a_block("basic");
    endtask

    task automatic test_sign_extend;
        a_vec = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFF, 8'hFE, 8'hFD, 8'hFC};
        a_exp = '{16'hFFFE, 16'hFFFC, 16'hFFFA, 16'hFFF8};
        run_a_block("sign");
    endtask

    task automatic test_back_to_back_stall;
        logic [7:0] v[6] = '{8'd5, 8'd7, 8'd5, 8'd7, 8'd5, 8'd7};
        logic [7:0] w[6] = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2};
        out_ready_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++; if (in_ready_b !== 1'b1) begin errors++; $display("FAIL stall_pass_ready%0d: got %b expected 1", i, in_ready_b); end
            in_valid_b = 1'b1; in_data_b = v[i];
        end
        // First sum is held, final-pass input blocked.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            in_data_b = v[5];
            checks++; if (out_valid_b !== 1'b1 || out_data_b !== 16'd15) begin errors++; $display("FAIL stall_hold%0d: got valid=%b data=%h expected valid=1 data=000f", k, out_valid_b, out_data_b); end
            checks++; if (in_ready_b !== 1'b0) begin errors++; $display("FAIL stall_in_ready%0d: got %b expected 0", k, in_ready_b); end
        end
        @(negedge clk);
        out_ready_b = 1'b1;
        #1;
        checks++; if (in_ready_b !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b expected 1", in_ready_b); end
        @(negedge clk); #1;
        checks++; if (out_valid_b !== 1'b1 || out_data_b !== 16'd21) begin errors++; $display("FAIL stall_no_bubble: got valid=%b data=%h expected valid=1 data=0015", out_valid_b, out_data_b); end
        out_ready_b = 1'b0;
        // Next block's accumulating passes overlap the undrained output.
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin @(negedge clk); #1; end
            checks++; if (in_ready_b !== 1'b1) begin errors++; $display("FAIL overlap_ready%0d: got %b expected 1", j, in_ready_b); end
            checks++; if (out_valid_b !== 1'b1 || out_data_b !== 16'd21) begin errors++; $display("FAIL overlap_hold%0d: got valid=%b data=%h expected valid=1 data=0015", j, out_valid_b, out_data_b); end
            in_valid_b = 1'b1; in_data_b = w[j];
        end
        @(negedge clk);
        in_data_b = w[4];
        #1;
        checks++; if (in_ready_b !== 1'b0) begin errors++; $display("FAIL overlap_final_stall: got %b expected 0", in_ready_b); end
        @(negedge clk);
        out_ready_b = 1'b1;
        @(negedge clk); #1;
        checks++; if (out_valid_b !== 1'b1 || out_data_b !== 16'd3) begin errors++; $display("FAIL block2_out0: got valid=%b data=%h expected valid=1 data=0003", out_valid_b, out_data_b); end
        in_data_b = w[5];
        @(negedge clk); #1;
        checks++; if (out_valid_b !== 1'b1 || out_data_b !== 16'd6) begin errors++; $display("FAIL block2_out1: got valid=%b data=%h expected valid=1 data=0006", out_valid_b, out_data_b); end
        in_valid_b = 1'b0;
        @(negedge clk); #1;
        checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL block2_drain: got valid=%b expected 0", out_valid_b); end
    endtask

    task automatic test_wrap;
        out_ready_c = 1'b1;
        @(negedge clk); in_valid_c = 1'b1; in_data_c = 8'd127;
        @(negedge clk); in_data_c = 8'd1;
        @(negedge clk); in_valid_c = 1'b0;
        #1;
        checks++; if (out_valid_c !== 1'b1 || out_data_c !== 8'h80) begin errors++; $display("FAIL wrap: got valid=%b data=%h expected valid=1 data=80", out_valid_c, out_data_c); end
    endtask

    task automatic test_reset_mid_pass;
        out_ready_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); in_valid_a = 1'b1; in_data_a = 8'd9;
        end
        @(negedge clk);
        in_valid_a = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid_a); end
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", in_ready_a); end
        @(negedge clk);
        rst = 1'b1;
        a_vec = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2};
        a_exp = '{16'd3, 16'd3, 16'd3, 16'd3};
        run_a_block("rst_fresh");
    endtask

    task automatic test_random_ready;
        logic [7:0]  v[3] = '{8'hFB, 8'd6, 8'd7};
        logic [15:0] got;
        logic        held = 1'b0;
        logic [15:0] held_data = '0;
        int idx = 0;
        int cyc = 0;
        exp_q = {16'hFFFB, 16'h0006, 16'h0007};
        while ((idx < 3 || exp_q.size() > 0) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            out_ready_d = 1'($urandom_range(0, 1));
            in_valid_d  = (idx < 3);
            in_data_d   = (idx < 3) ? v[idx] : 8'h00;
            #1;
            if (held) begin
                checks++;
                if (out_valid_d !== 1'b1 || out_data_d !== held_data) begin
                    errors++;
                    $display("FAIL rnd_stable: got valid=%b data=%h expected valid=1 data=%h", out_valid_d, out_data_d, held_data);
                end
            end
            if (out_valid_d && out_ready_d) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra: got data=%h expected no output", out_data_d);
                end else begin
                    got = exp_q.pop_front();
                    if (out_data_d !== got) begin
                        errors++;
                        $display("FAIL rnd_order: got %h expected %h", out_data_d, got);
                    end
                end
            end
            held      = out_valid_d && !out_ready_d;
            held_data = out_data_d;
            if (in_valid_d && in_ready_d) idx++;
        end
        in_valid_d = 1'b0;
        checks++;
        if (exp_q.size() != 0 || idx != 3) begin
            errors++;
            $display("FAIL rnd_timeout: got %0d outputs pending, %0d inputs sent expected 0 pending, 3 sent", exp_q.size(), idx);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_data_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b1;
        in_data_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b1;
        in_data_c = '0; in_valid_c = 1'b0; out_ready_c = 1'b1;
        in_data_d = '0; in_valid_d = 1'b0; out_ready_d = 1'b1;
        #1;
        test_reset();
        test_basic();
        test_sign_extend();
        test_back_to_back_stall();
        test_wrap();
        test_reset_mid_pass();
        test_random_ready();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
